// File: rtl/seq_alu_pkg.sv
// Shared opcode map, FSM state encoding and opcode helpers for seq_alu.
package seq_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NEG  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHRA = 4'd6;
  localparam logic [3:0] OP_MUL  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_MUL_IT  = 3'd1,
    S_DIV_IT  = 3'd2,
    S_DIV_FIX = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  function automatic logic is_illegal_op(input logic [3:0] op);
    return op > OP_ROR;
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared iterative datapath: radix-2 Booth multiplier and non-restoring divider
// operating on magnitudes, with a final restore/sign-fix step for division.
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             div_mode,
  input  logic             load,
  input  logic             step,
  input  logic             fix,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // Two guard bits: Booth needs room for A - M with M most-negative, and the
  // divider's shifted partial remainder spans [-2D, 2D) with D up to 2^(WIDTH-1).
  localparam int AW = WIDTH + 2;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] m_q, m_d;
  logic [WIDTH-1:0]     q_q, q_d;
  logic                 q1_q, q1_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;

  logic signed [AW-1:0] sum, shl, rem;
  logic [WIDTH-1:0]     a_mag, b_mag;

  always_comb begin
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    sum     = '0;
    shl     = '0;
    rem     = '0;
    a_mag   = a[WIDTH-1] ? -a : a;
    b_mag   = b[WIDTH-1] ? -b : b;

    if (load) begin
      acc_d = '0;
      q1_d  = 1'b0;
      if (div_mode) begin
        q_d     = a_mag;
        m_d     = {2'b00, b_mag};
        neg_q_d = a[WIDTH-1] ^ b[WIDTH-1];
        neg_r_d = a[WIDTH-1];
      end else begin
        q_d     = b;
        m_d     = {{2{a[WIDTH-1]}}, a};
        neg_q_d = 1'b0;
        neg_r_d = 1'b0;
      end
    end else if (step) begin
      if (div_mode) begin
        shl   = {acc_q[AW-2:0], q_q[WIDTH-1]};
        sum   = acc_q[AW-1] ? shl + m_q : shl - m_q;
        acc_d = sum;
        q_d   = {q_q[WIDTH-2:0], ~sum[AW-1]};
      end else begin
        case ({q_q[0], q1_q})
          2'b01:   sum = acc_q + m_q;
          2'b10:   sum = acc_q - m_q;
          default: sum = acc_q;
        endcase
        acc_d = sum >>> 1;
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        q1_d  = q_q[0];
      end
    end else if (fix) begin
      rem   = acc_q[AW-1] ? acc_q + m_q : acc_q;
      acc_d = neg_r_q ? -rem : rem;
      q_d   = neg_q_q ? -q_q : q_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  assign hi = acc_q[WIDTH-1:0];
  assign lo = q_q;

endmodule

// File: rtl/seq_alu.sv
// seq_alu: registered ALU with iterative MUL/DIV behind a start/busy/done handshake.
// Define SEQ_ALU_FLAGS_EN to build carry/overflow logic; otherwise both are tied to 0.
//
// state   | meaning
// IDLE    | waiting for start (a start during the done pulse is ignored)
// MUL_IT  | one Booth step per cycle, WIDTH steps
// DIV_IT  | one non-restoring step per cycle, WIDTH steps
// DIV_FIX | remainder restore and quotient/remainder sign fix-up
// DONE    | result and flags captured; done pulses in the following cycle
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero,
  output logic               div_by_zero,
  output logic               illegal_op,
  output logic               carry,
  output logic               overflow
);

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               zero_q, zero_d;
  logic               dbz_q, dbz_d;
  logic               ill_q, ill_d;

  logic               it_mode, it_load, it_step, it_fix;
  logic [WIDTH-1:0]   it_hi, it_lo;

  logic [WIDTH-1:0]   res_hi, res_lo;
  logic               res_dbz, res_ill;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] dbl;

  // The divider must be configured on the launch edge, before op_q is valid.
  assign it_mode = (state_q == S_IDLE) ? (op == OP_DIV) : (op_q == OP_DIV);

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clock    (clock),
    .clear_n  (clear_n),
    .div_mode (it_mode),
    .load     (it_load),
    .step     (it_step),
    .fix      (it_fix),
    .a        (a),
    .b        (b),
    .hi       (it_hi),
    .lo       (it_lo)
  );

  always_comb begin
    res_hi  = '0;
    res_lo  = '0;
    res_dbz = 1'b0;
    res_ill = 1'b0;
    sh      = b_q[SHW-1:0];
    dbl     = '0;
    case (op_q)
      OP_ADD:  res_lo = a_q + b_q;
      OP_SUB:  res_lo = a_q - b_q;
      OP_AND:  res_lo = a_q & b_q;
      OP_OR:   res_lo = a_q | b_q;
      OP_NEG:  res_lo = -a_q;
      OP_NOT:  res_lo = ~a_q;
      OP_SHRA: res_lo = $signed(a_q) >>> sh;
      OP_SHL:  res_lo = a_q << sh;
      OP_SHR:  res_lo = a_q >> sh;
      OP_ROL: begin
        dbl    = {a_q, a_q} << sh;
        res_lo = dbl[2*WIDTH-1:WIDTH];
      end
      OP_ROR: begin
        dbl    = {a_q, a_q} >> sh;
        res_lo = dbl[WIDTH-1:0];
      end
      OP_MUL: begin
        res_hi = it_hi;
        res_lo = it_lo;
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_hi  = a_q;
          res_lo  = '1;
          res_dbz = 1'b1;
        end else begin
          res_hi = it_hi;
          res_lo = it_lo;
        end
      end
      default: res_ill = is_illegal_op(op_q);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    dbz_d    = dbz_q;
    ill_d    = ill_q;
    it_load  = 1'b0;
    it_step  = 1'b0;
    it_fix   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          op_d = op;
          a_d  = a;
          b_d  = b;
          if (op == OP_MUL) begin
            state_d = S_MUL_IT;
            it_load = 1'b1;
            cnt_d   = SHW'(WIDTH - 1);
          end else if (op == OP_DIV && b != '0) begin
            state_d = S_DIV_IT;
            it_load = 1'b1;
            cnt_d   = SHW'(WIDTH - 1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_MUL_IT: begin
        it_step = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DIV_IT: begin
        it_step = 1'b1;
        if (cnt_q == '0) state_d = S_DIV_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DIV_FIX: begin
        it_fix  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_d   = 1'b1;
        result_d = {res_hi, res_lo};
        zero_d   = ({res_hi, res_lo} == '0);
        dbz_d    = res_dbz;
        ill_d    = res_ill;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      dbz_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      dbz_q    <= dbz_d;
      ill_q    <= ill_d;
    end
  end

`ifdef SEQ_ALU_FLAGS_EN
  logic carry_q, carry_d;
  logic overflow_q, overflow_d;

  // Carry derived from the wrapped sum/compare so no second adder is needed.
  always_comb begin
    carry_d    = carry_q;
    overflow_d = overflow_q;
    if (state_q == S_DONE) begin
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      case (op_q)
        OP_ADD: begin
          carry_d    = (res_lo < a_q);
          overflow_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_lo[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_SUB: begin
          carry_d    = (a_q >= b_q);
          overflow_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_lo[WIDTH-1] != a_q[WIDTH-1]);
        end
        OP_NEG: begin
          carry_d    = (a_q == '0);
          overflow_d = (a_q == {1'b1, {(WIDTH-1){1'b0}}});
        end
        OP_MUL:  overflow_d = (it_hi != {WIDTH{it_lo[WIDTH-1]}});
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign carry    = carry_q;
  assign overflow = overflow_q;
`else
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign illegal_op  = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed cases plus random ops against an arithmetic model.
module tb_seq_alu;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           clear_n, start;
  logic [3:0]     op;
  logic [W-1:0]   a, b;
  logic           busy, done, zero, div_by_zero, illegal_op, carry, overflow;
  logic [2*W-1:0] result;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [63:0] res;
    bit z, dbz, ill, c, v;
    int lat;
  } exp_t;

  seq_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero),
    .div_by_zero(div_by_zero), .illegal_op(illegal_op),
    .carry(carry), .overflow(overflow)
  );

  always #5 clock = ~clock;

  function automatic bit fits32(input longint v);
    return v == longint'(int'(v));
  endfunction

  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, p, qt, rm;
    int unsigned sh;
    logic [31:0] r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sh = y[4:0];
    r = x;
    e.res = '0; e.z = 0; e.dbz = 0; e.ill = 0; e.c = 0; e.v = 0; e.lat = 2;
    case (o)
      4'd0: begin e.res = {32'h0, 32'(x + y)}; e.c = ((longint'(x) + longint'(y)) >> 32) != 0; e.v = !fits32(sx + sy); end
      4'd1: begin e.res = {32'h0, 32'(x - y)}; e.c = (x >= y); e.v = !fits32(sx - sy); end
      4'd2: e.res = {32'h0, x & y};
      4'd3: e.res = {32'h0, x | y};
      4'd4: begin e.res = {32'h0, 32'(-sx)}; e.c = (x == 0); e.v = !fits32(-sx); end
      4'd5: e.res = {32'h0, ~x};
      4'd6: e.res = {32'h0, 32'(sx >>> sh)};
      4'd7: begin p = sx * sy; e.res = p; e.v = !fits32(p); e.lat = W + 2; end
      4'd8: e.res = {32'h0, x << sh};
      4'd9: e.res = {32'h0, x >> sh};
      4'd10: begin
        if (y == 0) begin
          e.res = {x, 32'hFFFF_FFFF}; e.dbz = 1;
        end else begin
          qt = sx / sy; rm = sx % sy;
          e.res = {32'(rm), 32'(qt)}; e.lat = W + 3;
        end
      end
      4'd11: begin repeat (sh) r = {r[30:0], r[31]}; e.res = {32'h0, r}; end
      4'd12: begin repeat (sh) r = {r[0], r[31:1]}; e.res = {32'h0, r}; end
      default: e.ill = 1;
    endcase
`ifndef SEQ_ALU_FLAGS_EN
    e.c = 0; e.v = 0;
`endif
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int n;
    bit seen;
    e = model(o, x, y);
    @(negedge clock); op = o; a = x; b = y; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    check({tag, " busy"}, busy, 1);
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(posedge clock); #1;
      n++;
      if (done) seen = 1;
      else check({tag, " busy_wait"}, busy, 1);
    end
    check({tag, " done"}, done, 1);
    if (seen) begin
      check({tag, " lat"}, n + 1, e.lat);
      check({tag, " res"}, result, e.res);
      check({tag, " zero"}, zero, e.z);
      check({tag, " dbz"}, div_by_zero, e.dbz);
      check({tag, " ill"}, illegal_op, e.ill);
      check({tag, " carry"}, carry, e.c);
      check({tag, " ovf"}, overflow, e.v);
      check({tag, " busy_done"}, busy, 0);
      op = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check({tag, " start_in_done"}, busy, 0);
      check({tag, " done_pulse"}, done, 0);
      check({tag, " held"}, result, e.res);
    end
  endtask

  initial begin
    exp_t e;
    int dones;
    logic [63:0] last;
    logic [3:0] ro;
    logic [31:0] ra, rb;

    clear_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst result", result, 0);
    check("rst zero", zero, 0);
    check("rst dbz", div_by_zero, 0);
    check("rst ill", illegal_op, 0);
    check("rst carry", carry, 0);
    check("rst ovf", overflow, 0);
    @(negedge clock); clear_n = 1'b1;

    run_op("mul_m3x7", 4'd7, -32'sd3, 32'd7);
    check("mul_m3x7 const", result, 64'hFFFFFFFF_FFFFFFEB);
    run_op("div_m17d5", 4'd10, -32'sd17, 32'd5);
    check("div_m17d5 const", result, {32'hFFFFFFFE, 32'hFFFFFFFD});
    run_op("div_ovf", 4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf const", result, {32'h0, 32'h8000_0000});
    run_op("div_9d0", 4'd10, 32'd9, 32'd0);
    check("div_9d0 const", result, {32'h9, 32'hFFFF_FFFF});
    run_op("add_1p1", 4'd0, 32'd1, 32'd1);
    check("add_1p1 const", result, 64'd2);
    run_op("ror", 4'd12, 32'h8000_0001, 32'd33);
    check("ror const", result, {32'h0, 32'hC000_0000});
    run_op("shra", 4'd6, 32'h8000_0000, 32'd4);
    check("shra const", result, {32'h0, 32'hF800_0000});
    run_op("sub_5m5", 4'd1, 32'd5, 32'd5);
    check("sub_5m5 zero", zero, 1);
    run_op("shl0", 4'd8, 32'h1234_5678, 32'd32);
    run_op("rol", 4'd11, 32'h8000_0001, 32'd4);
    run_op("illegal13", 4'd13, 32'd7, 32'd9);
    run_op("illegal15", 4'd15, 32'hFFFF_FFFF, 32'd1);
    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'd1);
    run_op("add_carry", 4'd0, 32'hFFFF_FFFF, 32'd1);
    run_op("neg_min", 4'd4, 32'h8000_0000, 32'd0);
    run_op("mul_big", 4'd7, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_op("mul_min", 4'd7, 32'h8000_0000, 32'h8000_0000);

    // start pulsed while a MUL is in flight must be ignored
    e = model(4'd7, 32'd123456, -32'sd789);
    @(negedge clock); op = 4'd7; a = 32'd123456; b = -32'sd789; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    dones = 0; last = '0;
    for (int i = 1; i <= 60; i++) begin
      if (i == 4) begin op = 4'd0; a = 32'd1; b = 32'd1; start = 1'b1; end
      @(posedge clock); #1;
      start = 1'b0;
      if (done) begin dones++; last = result; end
    end
    check("busy_ign dones", dones, 1);
    check("busy_ign res", last, e.res);

    // synchronous clear in the middle of a DIV
    @(negedge clock); op = 4'd10; a = 32'd1000; b = 32'd7; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock); clear_n = 1'b0;
    @(posedge clock); #1;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst result", result, 0);
    @(negedge clock); clear_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clock); #1;
      if (done) dones++;
    end
    check("midrst no_done", dones, 0);

    for (int k = 0; k < 80; k++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(0, 2);
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) rb = 32'hFFFF_FFFF;
      run_op($sformatf("rand%0d_op%0d", k, ro), ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
